// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: IF/ID fields and branch resolution in, per-stage controls and stalls out.
// StallCount/FlushCount exist only when CTRL_PERF_CNT_EN is defined.
interface pipelined_control_unit_if #(
    parameter int ALUOP_W = 5
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) ();
    logic [5:0]         OpCode;
    logic [5:0]         Funct;
    logic [4:0]         IFID_Rs;
    logic [4:0]         IFID_Rt;
    logic               BranchTaken;
    logic               PCWrite;
    logic               IFIDWrite;
    logic               IFID_Flush;
    logic [ALUOP_W-1:0] EX_AluOp;
    logic               EX_AluSrc;
    logic [1:0]         EX_RegDest;
    logic               EX_Branch;
    logic               EX_Jump;
    logic               MEM_MemRead;
    logic               MEM_MemWrite;
    logic [1:0]         MEM_ByteSel;
    logic               WB_RegWrite;
    logic [1:0]         WB_MemToReg;
    logic               MulBusy;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0]   StallCount;
    logic [CNT_W-1:0]   FlushCount;

    modport master (
        output OpCode, Funct, IFID_Rs, IFID_Rt, BranchTaken,
        input  PCWrite, IFIDWrite, IFID_Flush, EX_AluOp, EX_AluSrc, EX_RegDest,
               EX_Branch, EX_Jump, MEM_MemRead, MEM_MemWrite, MEM_ByteSel,
               WB_RegWrite, WB_MemToReg, MulBusy, StallCount, FlushCount
    );
    modport slave (
        input  OpCode, Funct, IFID_Rs, IFID_Rt, BranchTaken,
        output PCWrite, IFIDWrite, IFID_Flush, EX_AluOp, EX_AluSrc, EX_RegDest,
               EX_Branch, EX_Jump, MEM_MemRead, MEM_MemWrite, MEM_ByteSel,
               WB_RegWrite, WB_MemToReg, MulBusy, StallCount, FlushCount
    );
`else
    modport master (
        output OpCode, Funct, IFID_Rs, IFID_Rt, BranchTaken,
        input  PCWrite, IFIDWrite, IFID_Flush, EX_AluOp, EX_AluSrc, EX_RegDest,
               EX_Branch, EX_Jump, MEM_MemRead, MEM_MemWrite, MEM_ByteSel,
               WB_RegWrite, WB_MemToReg, MulBusy
    );
    modport slave (
        input  OpCode, Funct, IFID_Rs, IFID_Rt, BranchTaken,
        output PCWrite, IFIDWrite, IFID_Flush, EX_AluOp, EX_AluSrc, EX_RegDest,
               EX_Branch, EX_Jump, MEM_MemRead, MEM_MemWrite, MEM_ByteSel,
               WB_RegWrite, WB_MemToReg, MulBusy
    );
`endif
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers, load-use and
// multiply stalls, branch flush. Saturating stall/flush counters are added under CTRL_PERF_CNT_EN.
module pipelined_control_unit #(
    parameter int ALUOP_W    = 5,
    parameter int MUL_CYCLES = 3
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                    Clock,
    input  logic                    Reset,
    pipelined_control_unit_if.slave bus
);
    localparam int         MC_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [5:0] FN_JR = 6'b001000;

    typedef enum logic {IDLE, BUSY} mstate_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic [1:0]         regdest;
        logic               branch;
        logic               jump;
        logic               memread;
        logic               memwrite;
        logic [1:0]         bytesel;
        logic               regwrite;
        logic [1:0]         memtoreg;
        logic [4:0]         rt;
    } idex_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic [1:0] bytesel;
        logic       regwrite;
        logic [1:0] memtoreg;
    } exmem_t;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] memtoreg;
    } memwb_t;

    idex_t            dec;
    logic             dec_mul;
    idex_t            ex_p1;
    exmem_t           mem_p2;
    memwb_t           wb_p3;
    mstate_t          state;
    logic [MC_W-1:0]  mcnt;
    logic             busy;
    logic             load_use;
    logic             flush;
    logic             stall;

    always_comb begin
        dec     = '0;
        dec.rt  = bus.IFID_Rt;
        dec_mul = 1'b0;
        case (bus.OpCode)
            6'b000000: begin
                dec.jump     = (bus.Funct == FN_JR);
                dec.regwrite = (bus.Funct != FN_JR);
                dec.aluop    = ALUOP_W'(5'b00010);
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regdest  = 2'b01;
                dec.aluop    = ALUOP_W'({2'b10, bus.OpCode[2:0]});
            end
            6'b100000, 6'b100001, 6'b100011: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.regdest  = 2'b01;
                dec.memtoreg = 2'b01;
                dec.bytesel  = (bus.OpCode[1:0] == 2'b00) ? 2'b01 :
                               (bus.OpCode[1:0] == 2'b01) ? 2'b11 : 2'b00;
            end
            6'b101000, 6'b101001, 6'b101011: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                dec.regdest  = 2'b01;
                dec.memtoreg = 2'b11;
                dec.bytesel  = (bus.OpCode[1:0] == 2'b00) ? 2'b01 :
                               (bus.OpCode[1:0] == 2'b01) ? 2'b11 : 2'b00;
            end
            6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                dec.branch = 1'b1;
                dec.aluop  = ALUOP_W'(5'b00001);
            end
            6'b000010: dec.jump = 1'b1;
            6'b011100: begin
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_W'(5'b01100);
                dec_mul      = 1'b1;
            end
            default: ;
        endcase
    end

    // A busy multiply outranks a taken branch, which in turn outranks a load-use stall.
    assign busy     = (state == BUSY);
    assign load_use = ex_p1.memread && (ex_p1.rt != 5'd0) &&
                      ((ex_p1.rt == bus.IFID_Rs) || (ex_p1.rt == bus.IFID_Rt));
    assign flush    = !Reset && !busy && bus.BranchTaken;
    assign stall    = !Reset && (busy || (!flush && load_use));

    assign bus.PCWrite    = !stall;
    assign bus.IFIDWrite  = !stall;
    assign bus.IFID_Flush = flush;
    assign bus.MulBusy    = busy;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            mcnt   <= '0;
            ex_p1  <= '0;
            mem_p2 <= '0;
            wb_p3  <= '0;
        end else begin
            // MEM/WB stage boundary: always advances
            wb_p3.regwrite <= mem_p2.regwrite;
            wb_p3.memtoreg <= mem_p2.memtoreg;
            if (busy) begin
                // EX/MEM takes bubbles while ID/EX holds the multiply
                mem_p2 <= '0;
                mcnt   <= mcnt - MC_W'(1);
                if (mcnt == MC_W'(1))
                    state <= IDLE;
            end else begin
                // EX/MEM stage boundary
                mem_p2.memread  <= ex_p1.memread;
                mem_p2.memwrite <= ex_p1.memwrite;
                mem_p2.bytesel  <= ex_p1.bytesel;
                mem_p2.regwrite <= ex_p1.regwrite;
                mem_p2.memtoreg <= ex_p1.memtoreg;
                // ID/EX stage boundary
                if (flush || load_use) begin
                    ex_p1 <= '0;
                end else begin
                    ex_p1 <= dec;
                    if (dec_mul && (MUL_CYCLES > 1)) begin
                        state <= BUSY;
                        mcnt  <= MC_W'(MUL_CYCLES - 1);
                    end
                end
            end
        end
    end

    assign bus.EX_AluOp     = ex_p1.aluop;
    assign bus.EX_AluSrc    = ex_p1.alusrc;
    assign bus.EX_RegDest   = ex_p1.regdest;
    assign bus.EX_Branch    = ex_p1.branch;
    assign bus.EX_Jump      = ex_p1.jump;
    assign bus.MEM_MemRead  = mem_p2.memread;
    assign bus.MEM_MemWrite = mem_p2.memwrite;
    assign bus.MEM_ByteSel  = mem_p2.bytesel;
    assign bus.WB_RegWrite  = wb_p3.regwrite;
    assign bus.WB_MemToReg  = wb_p3.memtoreg;

`ifdef CTRL_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall)
                stall_cnt <= sat_inc(stall_cnt);
            if (flush)
                flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign bus.StallCount = stall_cnt;
    assign bus.FlushCount = flush_cnt;
`endif
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed pins plus randomized traffic compared every cycle
// against a stage-level behavioural model.
module tb_pipelined_control_unit;
    localparam int MULC = 3;
`ifdef CTRL_PERF_CNT_EN
    localparam int CNT_W = 2;
`endif
    localparam logic [5:0] NOPOP = 6'b111111;

    logic clk = 1'b0;
    logic rst = 1'b1;

`ifdef CTRL_PERF_CNT_EN
    pipelined_control_unit_if #(.ALUOP_W(5), .CNT_W(CNT_W)) bus ();
    pipelined_control_unit #(.ALUOP_W(5), .MUL_CYCLES(MULC), .CNT_W(CNT_W)) dut (
        .Clock(clk), .Reset(rst), .bus(bus));
`else
    pipelined_control_unit_if #(.ALUOP_W(5)) bus ();
    pipelined_control_unit #(.ALUOP_W(5), .MUL_CYCLES(MULC)) dut (
        .Clock(clk), .Reset(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] aluop;
        logic       alusrc;
        logic [1:0] regdest;
        logic       branch;
        logic       jump;
        logic       memread;
        logic       memwrite;
        logic [1:0] bytesel;
        logic       regwrite;
        logic [1:0] memtoreg;
    } bun_t;

    bun_t       mex, mmem, mwb;
    logic [4:0] mrt;
    bit         mmul;
    int         mage;
    bit         minit;
    int         mstall, mflush;
    int         nvec, nerr;

    logic [5:0] ops [20] = '{6'd0, 6'd0, 6'd8, 6'd10, 6'd14, 6'd15, 6'd32, 6'd33, 6'd35, 6'd35,
                             6'd40, 6'd41, 6'd43, 6'd1, 6'd4, 6'd7, 6'd2, 6'd28, 6'd28, 6'd63};

    // Table decode by opcode number.
    function automatic bun_t mdec(input int o, input int fn);
        bun_t b;
        b = '0;
        if (o == 0) begin
            b.jump = (fn == 8);
            b.regwrite = (fn != 8);
            b.aluop = 5'd2;
        end else if (o >= 8 && o <= 14) begin
            b.regwrite = 1; b.alusrc = 1; b.regdest = 2'd1;
            b.aluop = 5'(o + 8);
        end else if (o == 32 || o == 33 || o == 35) begin
            b.regwrite = 1; b.alusrc = 1; b.memread = 1; b.regdest = 2'd1; b.memtoreg = 2'd1;
            b.bytesel = (o == 32) ? 2'd1 : (o == 33) ? 2'd3 : 2'd0;
        end else if (o == 40 || o == 41 || o == 43) begin
            b.alusrc = 1; b.memwrite = 1; b.regdest = 2'd1; b.memtoreg = 2'd3;
            b.bytesel = (o == 40) ? 2'd1 : (o == 41) ? 2'd3 : 2'd0;
        end else if (o == 1 || (o >= 4 && o <= 7)) begin
            b.branch = 1; b.aluop = 5'd1;
        end else if (o == 2) begin
            b.jump = 1;
        end else if (o == 28) begin
            b.regwrite = 1; b.aluop = 5'd12;
        end
        return b;
    endfunction

    function automatic bit m_busy();
        return minit && mmul && (MULC > 1) && (mage < MULC - 1);
    endfunction
    function automatic bit m_flush();
        return !rst && !m_busy() && bus.BranchTaken;
    endfunction
    function automatic bit m_haz();
        return mex.memread && (mrt != 0) && (mrt == bus.IFID_Rs || mrt == bus.IFID_Rt);
    endfunction
    function automatic bit m_pcw();
        return rst || !(m_busy() || (!m_flush() && m_haz()));
    endfunction
    function automatic int sat(input int v);
`ifdef CTRL_PERF_CNT_EN
        return (v == (1 << CNT_W) - 1) ? v : v + 1;
`else
        return v + 1;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        chk(nm, act, exp);
    endtask

    task automatic compare();
        if (!minit) return;
        nvec++;
        chk("PCWrite", bus.PCWrite, m_pcw());
        chk("IFIDWrite", bus.IFIDWrite, m_pcw());
        chk("IFID_Flush", bus.IFID_Flush, m_flush());
        chk("MulBusy", bus.MulBusy, m_busy());
        chk("EX_AluOp", bus.EX_AluOp, mex.aluop);
        chk("EX_AluSrc", bus.EX_AluSrc, mex.alusrc);
        chk("EX_RegDest", bus.EX_RegDest, mex.regdest);
        chk("EX_Branch", bus.EX_Branch, mex.branch);
        chk("EX_Jump", bus.EX_Jump, mex.jump);
        chk("MEM_MemRead", bus.MEM_MemRead, mmem.memread);
        chk("MEM_MemWrite", bus.MEM_MemWrite, mmem.memwrite);
        chk("MEM_ByteSel", bus.MEM_ByteSel, mmem.bytesel);
        chk("WB_RegWrite", bus.WB_RegWrite, mwb.regwrite);
        chk("WB_MemToReg", bus.WB_MemToReg, mwb.memtoreg);
`ifdef CTRL_PERF_CNT_EN
        chk("StallCount", bus.StallCount, mstall);
        chk("FlushCount", bus.FlushCount, mflush);
`endif
    endtask

    task automatic model_edge();
        bit busy, fl, hz, pcw;
        busy = m_busy(); fl = m_flush(); hz = m_haz(); pcw = m_pcw();
        if (rst) begin
            mex = '0; mmem = '0; mwb = '0; mrt = 0; mmul = 0; mage = 0;
            mstall = 0; mflush = 0; minit = 1;
        end else begin
            if (!pcw) mstall = sat(mstall);
            if (fl) mflush = sat(mflush);
            mwb = mmem;
            if (busy) begin
                mmem = '0;
                mage++;
            end else begin
                mmem = mex;
                mage = 0;
                if (fl || hz) begin
                    mex = '0; mrt = 0; mmul = 0;
                end else begin
                    mex = mdec(int'(bus.OpCode), int'(bus.Funct));
                    mrt = bus.IFID_Rt;
                    mmul = (bus.OpCode == 6'd28);
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic bt);
        rst = r; bus.OpCode = op; bus.Funct = fn;
        bus.IFID_Rs = rs; bus.IFID_Rt = rt; bus.BranchTaken = bt;
        #1;
        compare();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
            adv();
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        nvec = 0; nerr = 0; minit = 0; mage = 0; mmul = 0; mrt = 0;
        mex = '0; mmem = '0; mwb = '0; mstall = 0; mflush = 0;

        drive(1, NOPOP, 6'd0, 5'd0, 5'd0, 0); adv();
        drive(1, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("rst_pcw", bus.PCWrite, 1); pin("rst_mulbusy", bus.MulBusy, 0);
        adv();

        // LW r5 then ADD using r5
        drive(0, 6'b100011, 6'd0, 5'd1, 5'd5, 0);
        pin("lw_ex_zero", bus.EX_AluSrc, 0); pin("lw_pcw", bus.PCWrite, 1);
        adv();
        drive(0, 6'b000000, 6'b100000, 5'd5, 5'd2, 0);
        pin("lw_ex_alusrc", bus.EX_AluSrc, 1); pin("lu_pcw", bus.PCWrite, 0);
        pin("lu_ifidw", bus.IFIDWrite, 0);
        adv();
        drive(0, 6'b000000, 6'b100000, 5'd5, 5'd2, 0);
        pin("lw_mem_rd", bus.MEM_MemRead, 1); pin("lu_ex_nop", bus.EX_AluSrc, 0);
        pin("lu_release", bus.PCWrite, 1);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("lw_wb_m2r", bus.WB_MemToReg, 2'b01); pin("add_ex_aluop", bus.EX_AluOp, 5'd2);
        adv();
        nops(3);

        // multiply occupying EX for MULC cycles
        drive(0, 6'b011100, 6'd0, 5'd0, 5'd0, 0);
        pin("mul_pre_busy", bus.MulBusy, 0); pin("mul_pre_pcw", bus.PCWrite, 1);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("mul_a_busy", bus.MulBusy, 1); pin("mul_a_pcw", bus.PCWrite, 0);
        pin("mul_a_aluop", bus.EX_AluOp, 5'b01100);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("mul_b_busy", bus.MulBusy, 1); pin("mul_b_pcw", bus.PCWrite, 0);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("mul_c_busy", bus.MulBusy, 0); pin("mul_c_pcw", bus.PCWrite, 1);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("mul_d_wb", bus.WB_RegWrite, 0);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("mul_e_wb", bus.WB_RegWrite, 1);
        adv();
        drive(0, 6'b011100, 6'd0, 5'd0, 5'd0, 0); adv();
        nops(3);
`ifdef CTRL_PERF_CNT_EN
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("stall_sat", bus.StallCount, 2'b11);
        adv();
`endif

        // taken branch beats load-use
        drive(0, 6'b100011, 6'd0, 5'd0, 5'd7, 0); adv();
        drive(0, 6'b001000, 6'd0, 5'd7, 5'd3, 1);
        pin("br_flush", bus.IFID_Flush, 1); pin("br_pcw", bus.PCWrite, 1);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("br_ex_nop", bus.EX_AluSrc, 0); pin("br_mem_ld", bus.MEM_MemRead, 1);
        adv();
        nops(2);

        // reset in the second busy cycle
        drive(0, 6'b011100, 6'd0, 5'd0, 5'd0, 0); adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("rb_a_busy", bus.MulBusy, 1);
        adv();
        drive(1, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("rb_b_busy", bus.MulBusy, 1);
        adv();
        drive(0, NOPOP, 6'd0, 5'd0, 5'd0, 0);
        pin("rb_busy_clr", bus.MulBusy, 0); pin("rb_pcw", bus.PCWrite, 1);
        pin("rb_ex_nop", bus.EX_AluOp, 0); pin("rb_wb_nop", bus.WB_RegWrite, 0);
        adv();

        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 19)];
            fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
            drive(($urandom_range(0, 149) == 0), op, fn,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0));
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
